// File: rtl/execute_alu_issue_arbiter_if.sv
// Issue-side and ALU-side handshake bundle for the shared ALU execute port arbiter.
// The master modport is the arbiter; the slave modport is the surrounding scheduler/port.
interface execute_alu_issue_arbiter_if #(
  parameter int P_PAYLOAD_W = 128
);
  logic                   iREQ0_VALID;
  logic [P_PAYLOAD_W-1:0] iREQ0_PAYLOAD;
  logic                   oREQ0_ACK;
  logic                   iREQ1_VALID;
  logic [P_PAYLOAD_W-1:0] iREQ1_PAYLOAD;
  logic                   oREQ1_ACK;
  logic                   oALU_VALID;
  logic [P_PAYLOAD_W-1:0] oALU_PAYLOAD;
  logic                   oALU_SRC;
  logic                   iALU_LOCK;

  modport master (
    input  iREQ0_VALID, iREQ0_PAYLOAD, iREQ1_VALID, iREQ1_PAYLOAD, iALU_LOCK,
    output oREQ0_ACK, oREQ1_ACK, oALU_VALID, oALU_PAYLOAD, oALU_SRC
  );

  modport slave (
    output iREQ0_VALID, iREQ0_PAYLOAD, iREQ1_VALID, iREQ1_PAYLOAD, iALU_LOCK,
    input  oREQ0_ACK, oREQ1_ACK, oALU_VALID, oALU_PAYLOAD, oALU_SRC
  );
endinterface

// File: rtl/execute_alu_issue_arbiter.sv
// Round-robin share of one ALU port between two reservation stations; 1-cycle registered output.
// Lock stalls the output stage and withholds acks; flush empties it. EXE_ALU_ARB_PERF_CNT_EN adds grant counters.
module execute_alu_issue_arbiter #(
  parameter int P_PAYLOAD_W = 128,
  parameter int P_PERF_W    = 16
) (
  input  logic                       iCLOCK,
  input  logic                       iRESET_SYNC,
  input  logic                       iFREE_EX,
  execute_alu_issue_arbiter_if.master alu_bus,
  output logic [P_PERF_W-1:0]        oPERF_GRANT0,
  output logic [P_PERF_W-1:0]        oPERF_GRANT1
);

  logic                   out_valid;
  logic [P_PAYLOAD_W-1:0] out_payload;
  logic                   out_src;
  logic                   rr_ptr;

  logic accept;
  logic grant_vld;
  logic grant_id;

  // Reset is folded into accept so no ack can leak out while the stage is being cleared.
  always_comb begin
    accept    = !iRESET_SYNC && !iFREE_EX && (!out_valid || !alu_bus.iALU_LOCK);
    grant_vld = accept && (alu_bus.iREQ0_VALID || alu_bus.iREQ1_VALID);
    grant_id  = (alu_bus.iREQ0_VALID && alu_bus.iREQ1_VALID) ? rr_ptr : alu_bus.iREQ1_VALID;
  end

  assign alu_bus.oREQ0_ACK    = grant_vld && !grant_id;
  assign alu_bus.oREQ1_ACK    = grant_vld &&  grant_id;
  assign alu_bus.oALU_VALID   = out_valid;
  assign alu_bus.oALU_PAYLOAD = out_payload;
  assign alu_bus.oALU_SRC     = out_src;

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC || iFREE_EX) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_src     <= 1'b0;
      rr_ptr      <= 1'b0;
    end else if (grant_vld) begin
      out_valid   <= 1'b1;
      out_payload <= grant_id ? alu_bus.iREQ1_PAYLOAD : alu_bus.iREQ0_PAYLOAD;
      out_src     <= grant_id;
      rr_ptr      <= ~grant_id;
    end else if (accept) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef EXE_ALU_ARB_PERF_CNT_EN
  logic [P_PERF_W-1:0] perf_cnt0;
  logic [P_PERF_W-1:0] perf_cnt1;

  // Counters survive pipeline flushes; only reset clears them.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      if (alu_bus.oREQ0_ACK) perf_cnt0 <= perf_cnt0 + P_PERF_W'(1);
      if (alu_bus.oREQ1_ACK) perf_cnt1 <= perf_cnt1 + P_PERF_W'(1);
    end
  end

  assign oPERF_GRANT0 = perf_cnt0;
  assign oPERF_GRANT1 = perf_cnt1;
`else
  assign oPERF_GRANT0 = '0;
  assign oPERF_GRANT1 = '0;
`endif

endmodule

// File: tb/tb_execute_alu_issue_arbiter.sv
// Directed bench for execute_alu_issue_arbiter: acks checked per cycle, payloads via a scoreboard queue.
module tb_execute_alu_issue_arbiter;
  localparam int PW = 128;
  localparam int CW = 4;

  typedef struct {
    logic [PW-1:0] payload;
    logic          src;
  } sb_t;

  logic          iCLOCK = 1'b0;
  logic          iRESET_SYNC;
  logic          iFREE_EX;
  logic [CW-1:0] oPERF_GRANT0;
  logic [CW-1:0] oPERF_GRANT1;

  execute_alu_issue_arbiter_if #(.P_PAYLOAD_W(PW)) bus ();

  execute_alu_issue_arbiter #(.P_PAYLOAD_W(PW), .P_PERF_W(CW)) dut (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iFREE_EX    (iFREE_EX),
    .alu_bus     (bus),
    .oPERF_GRANT0(oPERF_GRANT0),
    .oPERF_GRANT1(oPERF_GRANT1)
  );

  always #5 iCLOCK = ~iCLOCK;

  int            errors = 0;
  int            checks = 0;
  sb_t           sb[$];
  logic [CW-1:0] exp_cnt0 = '0;
  logic [CW-1:0] exp_cnt1 = '0;
  logic [PW-1:0] pay_a;
  logic [PW-1:0] pay_b;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"},   PW'(bus.oALU_VALID),   '0);
    chk({tag, "_payload"}, bus.oALU_PAYLOAD,      '0);
    chk({tag, "_src"},     PW'(bus.oALU_SRC),     '0);
  endtask

  // One clock: check acks and consumed output at the negedge, then advance past the rising edge.
  task automatic cyc(input logic ea0, input logic ea1);
    sb_t  e;
    logic was_rst;
    logic was_clr;
    @(negedge iCLOCK);
    chk("ack0", PW'(bus.oREQ0_ACK), PW'(ea0));
    chk("ack1", PW'(bus.oREQ1_ACK), PW'(ea1));
    if (bus.oALU_VALID && !bus.iALU_LOCK && !iFREE_EX && !iRESET_SYNC) begin
      chk("sb_occupied", PW'(sb.size() > 0), PW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alu_payload", bus.oALU_PAYLOAD, e.payload);
        chk("alu_src", PW'(bus.oALU_SRC), PW'(e.src));
      end
    end
    if (ea0) sb.push_back('{payload: bus.iREQ0_PAYLOAD, src: 1'b0});
    if (ea1) sb.push_back('{payload: bus.iREQ1_PAYLOAD, src: 1'b1});
    was_rst = iRESET_SYNC;
    was_clr = iRESET_SYNC || iFREE_EX;
    @(posedge iCLOCK);
    #1;
    if (was_rst) begin
      exp_cnt0 = '0;
      exp_cnt1 = '0;
    end else begin
      if (ea0) exp_cnt0 = exp_cnt0 + CW'(1);
      if (ea1) exp_cnt1 = exp_cnt1 + CW'(1);
    end
    if (was_clr) sb.delete();
`ifdef EXE_ALU_ARB_PERF_CNT_EN
    chk("perf0", PW'(oPERF_GRANT0), PW'(exp_cnt0));
    chk("perf1", PW'(oPERF_GRANT1), PW'(exp_cnt1));
`else
    chk("perf0_tied", PW'(oPERF_GRANT0), '0);
    chk("perf1_tied", PW'(oPERF_GRANT1), '0);
`endif
  endtask

  task automatic drive(input logic v0, input logic v1, input logic lock);
    bus.iREQ0_VALID = v0;
    bus.iREQ1_VALID = v1;
    bus.iALU_LOCK   = lock;
  endtask

  initial begin
    pay_a = PW'(8'h11);
    pay_b = PW'(8'h22);
    bus.iREQ0_PAYLOAD = pay_a;
    bus.iREQ1_PAYLOAD = pay_b;
    iRESET_SYNC = 1'b1;
    iFREE_EX    = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    #1;

    // Reset with flush and requests present.
    cyc(0, 0);
    cyc(0, 0);
    chk_outputs_zero("reset");

    // Fairness: both valid, alternate 0,1,0.
    iRESET_SYNC = 1'b0;
    iFREE_EX    = 1'b0;
    cyc(1, 0);
    chk("first_payload", bus.oALU_PAYLOAD, pay_a);
    chk("first_valid", PW'(bus.oALU_VALID), PW'(1));
    cyc(0, 1);
    cyc(1, 0);

    // Only REQ1 valid: acked every cycle, priority returns to REQ0.
    drive(1'b0, 1'b1, 1'b0);
    cyc(0, 1);
    cyc(0, 1);
    cyc(0, 1);
    chk("req1_only_src", PW'(bus.oALU_SRC), PW'(1));
    drive(1'b1, 1'b1, 1'b0);
    cyc(1, 0);

    // Lock with 0x11 held and both requesters valid.
    drive(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0);
      chk("lock_hold_payload", bus.oALU_PAYLOAD, pay_a);
      chk("lock_hold_valid", PW'(bus.oALU_VALID), PW'(1));
    end
    drive(1'b1, 1'b1, 1'b0);
    cyc(0, 1);
    drive(1'b1, 1'b0, 1'b0);
    cyc(1, 0);

    // Flush while locked with a held micro-op; priority pointer must return to REQ0.
    drive(1'b1, 1'b1, 1'b1);
    iFREE_EX = 1'b1;
    cyc(0, 0);
    iFREE_EX = 1'b0;
    chk_outputs_zero("flush");
    cyc(1, 0);
    drive(1'b1, 1'b1, 1'b0);
    cyc(0, 1);

    // Drain, then lock while empty has no effect.
    drive(1'b0, 1'b0, 1'b0);
    cyc(0, 0);
    chk("drain_valid", PW'(bus.oALU_VALID), PW'(0));
    drive(1'b1, 1'b0, 1'b1);
    cyc(1, 0);
    chk("lock_empty_valid", PW'(bus.oALU_VALID), PW'(1));

    // Reset together with flush and requests.
    iRESET_SYNC = 1'b1;
    iFREE_EX    = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    cyc(0, 0);
    chk_outputs_zero("reset_flush");
    iRESET_SYNC = 1'b0;
    iFREE_EX    = 1'b0;

    // 17 REQ0 grants: a 4-bit counter wraps to 1.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cyc(1, 0);
    drive(1'b0, 1'b0, 1'b0);
    cyc(0, 0);
`ifdef EXE_ALU_ARB_PERF_CNT_EN
    chk("perf0_wrapped", PW'(oPERF_GRANT0), PW'(1));
    chk("perf1_idle", PW'(oPERF_GRANT1), PW'(0));
`else
    chk("perf0_const", PW'(oPERF_GRANT0), '0);
    chk("perf1_const", PW'(oPERF_GRANT1), '0);
`endif
    chk("sb_empty", PW'(sb.size() == 0), PW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
